// File: rtl/hazard_pkg.sv
// Shared hazard-control types: FSM state encoding and EX forward selects.
// fwdSel() picks the youngest in-flight producer for one EX source register.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hazState_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    function automatic logic [1:0] fwdSel(
        input logic [4:0] rs,
        input logic [4:0] rdM,
        input logic       wEnM,
        input logic [4:0] rdW,
        input logic       wEnW
    );
        if (wEnM && rdM != 5'd0 && rdM == rs) begin
            return FWD_M;
        end
        if (wEnW && rdW != 5'd0 && rdW == rs) begin
            return FWD_W;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
// Ports: clk, reset (async, high), inc (count enable), count (stops at all-ones).
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && count != '1) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: memory-wait stall/timeout FSM, redirect and load-use
// handling, EX operand forwarding, and stall/flush performance counters.
// Ports: ID/EX/MEM/WB register ids and enables in; Stall*/Flush*, Forward*E,
// MemErr and StallCnt/FlushCnt out. clk rising edge, reset async active-high.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             RegWEnE,
    input  logic             WBSelE,
    input  logic             PCSelE,
    input  logic [4:0]       RdM,
    input  logic             RegWEnM,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    input  logic [4:0]       RdW,
    input  logic             RegWEnW,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    hazState_t         state, stateNext;
    logic [WAIT_W-1:0] waitCnt, waitCntNext;

    logic memWait, loadUse;
    logic stallAll, stallFD, flushDE, flushEOnly, flushWb;

    assign memWait = MemReqM && !MemReadyM;
    assign loadUse = RegWEnE && WBSelE && RdE != 5'd0
                     && (RdE == Rs1D || RdE == Rs2D);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            waitCnt <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
        end
    end

    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        stallAll    = 1'b0;
        stallFD     = 1'b0;
        flushDE     = 1'b0;
        flushEOnly  = 1'b0;
        flushWb     = 1'b0;
        unique case (state)
            RUN: begin
                if (memWait) begin
                    stallAll    = 1'b1;
                    flushWb     = 1'b1;
                    waitCntNext = WAIT_ONE;
                    stateNext   = (TIMEOUT_CYCLES <= 1) ? ERROR : MEM_WAIT;
                end else if (PCSelE) begin
                    flushDE = 1'b1;
                end else if (loadUse) begin
                    stallFD    = 1'b1;
                    flushEOnly = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!MemReadyM) begin
                    stallAll = 1'b1;
                    flushWb  = 1'b1;
                    if (waitCnt >= WAIT_LAST) begin
                        stateNext = ERROR;
                    end else begin
                        waitCntNext = waitCnt + 1'b1;
                    end
                end else begin
                    // Release cycle: pipeline advances, so a redirect or
                    // load-use held in EX during the wait is acted on now.
                    stateNext   = RUN;
                    waitCntNext = '0;
                    if (PCSelE) begin
                        flushDE = 1'b1;
                    end else if (loadUse) begin
                        stallFD    = 1'b1;
                        flushEOnly = 1'b1;
                    end
                end
            end
            ERROR: begin
                stallAll = 1'b1;
            end
            default: begin
                stateNext   = RUN;
                waitCntNext = '0;
            end
        endcase
    end

    // Reset forces every stall/flush low even though inputs still toggle.
    assign StallF = !reset && (stallAll || stallFD);
    assign StallD = !reset && (stallAll || stallFD);
    assign StallE = !reset && stallAll;
    assign StallM = !reset && stallAll;
    assign FlushD = !reset && flushDE;
    assign FlushE = !reset && (flushDE || flushEOnly);
    assign FlushW = !reset && flushWb;
    assign MemErr = (state == ERROR);

    assign ForwardAE = fwdSel(Rs1E, RdM, RegWEnM, RdW, RegWEnW);
    assign ForwardBE = fwdSel(Rs2E, RdM, RegWEnM, RdW, RegWEnW);

    sat_counter #(.WIDTH(CNT_W)) uStallCnt (
        .clk   (clk),
        .reset (reset),
        .inc   (StallF),
        .count (StallCnt)
    );

    sat_counter #(.WIDTH(CNT_W)) uFlushCnt (
        .clk   (clk),
        .reset (reset),
        .inc   (FlushE),
        .count (FlushCnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic,
// expected outputs from an episode-level reference model.
module tb_hazard_ctrl;

    localparam int TO    = 4;
    localparam int CW    = 6;
    localparam int CMAX  = (1 << CW) - 1;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE;
        logic       regWEnE, wbSelE, pcSelE;
        logic [4:0] rdM;
        logic       regWEnM, memReqM, memReadyM;
        logic [4:0] rdW;
        logic       regWEnW;
    } in_t;

    typedef struct {
        logic [3:0] stall;
        logic [2:0] flush;
        logic [1:0] fa, fb;
        logic       err;
        int         sc, fc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, RdE = '0;
    logic RegWEnE = 0, WBSelE = 0, PCSelE = 0;
    logic [4:0] RdM = '0, RdW = '0;
    logic RegWEnM = 0, MemReqM = 0, MemReadyM = 0, RegWEnW = 0;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic [1:0] ForwardAE, ForwardBE;
    logic [CW-1:0] StallCnt, FlushCnt;

    hazard_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RegWEnE(RegWEnE), .WBSelE(WBSelE), .PCSelE(PCSelE),
        .RdM(RdM), .RegWEnM(RegWEnM), .MemReqM(MemReqM),
        .MemReadyM(MemReadyM), .RdW(RdW), .RegWEnW(RegWEnW),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemErr(MemErr),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    // Reference state: length of the current memory-wait episode (0 = none),
    // error latch, and plain integer event tallies.
    int  mEpisode = 0;
    bit  mErr = 0;
    int  mSc = 0;
    int  mFc = 0;

    function automatic logic [1:0] refFwd(input in_t v, input logic [4:0] rs);
        if (v.regWEnM && v.rdM != 0 && v.rdM == rs) return 2'b10;
        if (v.regWEnW && v.rdW != 0 && v.rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic in_t idle();
        in_t v;
        v = '0;
        return v;
    endfunction

    task automatic step(input in_t v);
        exp_t e;
        bit lu;
        @(posedge clk);
        #1;
        reset = v.rst;
        Rs1D = v.rs1D; Rs2D = v.rs2D; Rs1E = v.rs1E; Rs2E = v.rs2E;
        RdE = v.rdE; RegWEnE = v.regWEnE; WBSelE = v.wbSelE;
        PCSelE = v.pcSelE; RdM = v.rdM; RegWEnM = v.regWEnM;
        MemReqM = v.memReqM; MemReadyM = v.memReadyM;
        RdW = v.rdW; RegWEnW = v.regWEnW;
        e.fa = refFwd(v, v.rs1E);
        e.fb = refFwd(v, v.rs2E);
        e.stall = '0;
        e.flush = '0;
        if (v.rst) begin
            mEpisode = 0; mErr = 0; mSc = 0; mFc = 0;
            e.err = 0; e.sc = 0; e.fc = 0;
            q.push_back(e);
            return;
        end
        e.err = mErr;
        e.sc = mSc;
        e.fc = mFc;
        lu = v.regWEnE && v.wbSelE && v.rdE != 0
             && (v.rdE == v.rs1D || v.rdE == v.rs2D);
        if (mErr) begin
            e.stall = 4'b1111;
        end else if (mEpisode > 0 && !v.memReadyM) begin
            e.stall = 4'b1111;
            e.flush = 3'b001;
            mEpisode++;
            if (mEpisode >= TO) mErr = 1;
        end else if (mEpisode == 0 && v.memReqM && !v.memReadyM) begin
            e.stall = 4'b1111;
            e.flush = 3'b001;
            mEpisode = 1;
            if (TO <= 1) mErr = 1;
        end else begin
            mEpisode = 0;
            if (v.pcSelE) e.flush = 3'b110;
            else if (lu) begin
                e.stall = 4'b1100;
                e.flush = 3'b010;
            end
        end
        if (e.stall[3]) mSc = (mSc < CMAX) ? mSc + 1 : CMAX;
        if (e.flush[1]) mFc = (mFc < CMAX) ? mFc + 1 : CMAX;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        logic [3:0] gs;
        logic [2:0] gf;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                gs = {StallF, StallD, StallE, StallM};
                gf = {FlushD, FlushE, FlushW};
                if (gs !== e.stall || gf !== e.flush || ForwardAE !== e.fa
                    || ForwardBE !== e.fb || MemErr !== e.err
                    || int'(StallCnt) != e.sc || int'(FlushCnt) != e.fc) begin
                    miscompares++;
                    $display("FAIL vec%0d @%0t got/exp stall=%b/%b flush=%b/%b fa=%b/%b fb=%b/%b err=%b/%b sc=%0d/%0d fc=%0d/%0d",
                             vectors, $time, gs, e.stall, gf, e.flush,
                             ForwardAE, e.fa, ForwardBE, e.fb, MemErr, e.err,
                             StallCnt, e.sc, FlushCnt, e.fc);
                end
            end
        end
    end

    initial begin : stim
        in_t v;
        // Reset state.
        v = idle(); v.rst = 1;
        step(v); step(v);
        // Load-use on Rs2D.
        v = idle(); v.rdE = 5; v.wbSelE = 1; v.regWEnE = 1; v.rs2D = 5;
        step(v);
        step(idle()); step(idle());
        // Redirect beats load-use.
        v.pcSelE = 1;
        step(v);
        step(idle());
        // Three-cycle memory wait, then release.
        v = idle(); v.memReqM = 1;
        repeat (3) step(v);
        v.memReadyM = 1;
        step(v);
        step(idle());
        // Redirect held in EX across a wait, taken on release.
        v = idle(); v.memReqM = 1; v.pcSelE = 1;
        repeat (2) step(v);
        v.memReadyM = 1;
        step(v);
        step(idle());
        // Forwarding priority.
        v = idle(); v.rdM = 7; v.rdW = 7; v.regWEnM = 1; v.regWEnW = 1;
        v.rs1E = 7; v.rs2E = 7;
        step(v);
        v.rdM = 0;
        step(v);
        v.rs1E = 0;
        step(v);
        // Timeout into ERROR, long enough to saturate StallCnt.
        v = idle(); v.memReqM = 1;
        repeat (TO + 70) step(v);
        v = idle(); v.rst = 1;
        step(v);
        step(idle());
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            v.rst = ($urandom_range(0, 39) == 0);
            v.rs1D = 5'($urandom_range(0, 7));
            v.rs2D = 5'($urandom_range(0, 7));
            v.rs1E = 5'($urandom_range(0, 7));
            v.rs2E = 5'($urandom_range(0, 7));
            v.rdE = 5'($urandom_range(0, 7));
            v.rdM = 5'($urandom_range(0, 7));
            v.rdW = 5'($urandom_range(0, 7));
            v.regWEnE = 1'($urandom);
            v.wbSelE = 1'($urandom);
            v.pcSelE = ($urandom_range(0, 5) == 0);
            v.regWEnM = 1'($urandom);
            v.regWEnW = 1'($urandom);
            v.memReqM = ($urandom_range(0, 5) == 0) || (mEpisode > 0);
            v.memReadyM = ($urandom_range(0, 2) == 0);
            step(v);
        end
        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
